// File: rtl/arb_grant_decoder_pkg.sv
// Shared types and helpers for the arbiter grant decoder and its hold timer.
package arb_grant_decoder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Timer must be able to hold TIMEOUT itself so it can saturate there.
    function automatic int timer_width(input int timeout);
        if (timeout > 0) begin
            return $clog2(timeout + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/arb_grant_timer.sv
// Saturating grant-hold counter; expire_o flags the last permitted hold cycle.
module arb_grant_timer
    import arb_grant_decoder_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int TW = timer_width(TIMEOUT);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] CNT_MAX  = TW'(TIMEOUT);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Counter register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= {TW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Clear has priority; counting stops at CNT_MAX instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {TW{1'b0}};
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign expire_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/arb_grant_decoder.sv
// Turns an encoded grant index into a held, registered one-hot grant that is
// dropped on the owner's release or on an optional hold timeout.
module arb_grant_decoder
    import arb_grant_decoder_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int IDX_W   = $clog2(WIDTH),
    parameter int TIMEOUT = 0
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             enc_valid_i,
    input  logic [IDX_W-1:0] enc_idx_i,
    output logic             enc_ready_o,
    output logic [WIDTH-1:0] grant_o,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o,
    input  logic [WIDTH-1:0] release_i,
    output logic             timeout_o,
    output logic             err_o
);

    localparam logic [IDX_W:0]   WIDTH_L = (IDX_W + 1)'(WIDTH);
    localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             timeout_q, timeout_d;
    logic             err_q, err_d;
    logic             accept_s;
    logic             in_range_s;
    logic             expire_s;

    assign accept_s   = enc_valid_i && (state_q == ST_IDLE);
    assign in_range_s = ({1'b0, enc_idx_i} < WIDTH_L);

    if (TIMEOUT > 0) begin : g_timer
        arb_grant_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .clk_i    (clk_i),
            .arst_n_i (arst_n_i),
            .clr_i    (accept_s),
            .en_i     (state_q == ST_GRANT),
            .expire_o (expire_s)
        );
    end else begin : g_no_timer
        assign expire_s = 1'b0;
    end

    // State and output registers; async reset drops the grant immediately.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= {WIDTH{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic; a matching release beats a same-cycle timeout.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && in_range_s) begin
                    idx_d   = enc_idx_i;
                    grant_d = ONE_HOT0 << enc_idx_i;
                    state_d = ST_GRANT;
                end else if (accept_s) begin
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (|(release_i & grant_q)) begin
                    grant_d = {WIDTH{1'b0}};
                    state_d = ST_IDLE;
                end else if (expire_s) begin
                    grant_d   = {WIDTH{1'b0}};
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                grant_d = {WIDTH{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    assign enc_ready_o   = (state_q == ST_IDLE);
    assign grant_o       = grant_q;
    assign grant_valid_o = |grant_q;
    assign grant_idx_o   = idx_q;
    assign timeout_o     = timeout_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_arb_grant_decoder.sv
// Directed bench for arb_grant_decoder: plain (W=4), timeout (W=4,T=8) and
// non-power-of-two (W=5) instances share one clock and reset.
module tb_arb_grant_decoder;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // Instance a: WIDTH=4, no timeout
    logic       a_valid, a_ready, a_gv, a_to, a_err;
    logic [1:0] a_idx, a_gidx;
    logic [3:0] a_grant, a_rel;
    // Instance t: WIDTH=4, TIMEOUT=8
    logic       t_valid, t_ready, t_gv, t_to, t_err;
    logic [1:0] t_idx, t_gidx;
    logic [3:0] t_grant, t_rel;
    // Instance f: WIDTH=5, no timeout
    logic       f_valid, f_ready, f_gv, f_to, f_err;
    logic [2:0] f_idx, f_gidx;
    logic [4:0] f_grant, f_rel;

    arb_grant_decoder #(.WIDTH(4), .TIMEOUT(0)) u_a (
        .clk_i(clk), .arst_n_i(arst_n), .enc_valid_i(a_valid), .enc_idx_i(a_idx),
        .enc_ready_o(a_ready), .grant_o(a_grant), .grant_valid_o(a_gv),
        .grant_idx_o(a_gidx), .release_i(a_rel), .timeout_o(a_to), .err_o(a_err));

    arb_grant_decoder #(.WIDTH(4), .TIMEOUT(8)) u_t (
        .clk_i(clk), .arst_n_i(arst_n), .enc_valid_i(t_valid), .enc_idx_i(t_idx),
        .enc_ready_o(t_ready), .grant_o(t_grant), .grant_valid_o(t_gv),
        .grant_idx_o(t_gidx), .release_i(t_rel), .timeout_o(t_to), .err_o(t_err));

    arb_grant_decoder #(.WIDTH(5), .TIMEOUT(0)) u_f (
        .clk_i(clk), .arst_n_i(arst_n), .enc_valid_i(f_valid), .enc_idx_i(f_idx),
        .enc_ready_o(f_ready), .grant_o(f_grant), .grant_valid_o(f_gv),
        .grant_idx_o(f_gidx), .release_i(f_rel), .timeout_o(f_to), .err_o(f_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_valid = 1'b0; a_idx = 2'd0; a_rel = 4'b0000;
        t_valid = 1'b0; t_idx = 2'd0; t_rel = 4'b0000;
        f_valid = 1'b0; f_idx = 3'd0; f_rel = 5'b00000;
        arst_n = 1'b0;
        #12;
        vectors++;
        if ({a_grant, a_gv, a_gidx, a_to, a_err, a_ready} !== {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset_state: got grant=%b gv=%b idx=%0d to=%b err=%b rdy=%b want 0000/0/0/0/0/1",
                     a_grant, a_gv, a_gidx, a_to, a_err, a_ready);
            miscompares++;
        end
        arst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_grant();
        a_valid = 1'b1; a_idx = 2'd2;
        tick();
        a_valid = 1'b0;
        vectors++;
        if ({a_grant, a_ready, a_gv, a_gidx} !== {4'b0100, 1'b0, 1'b1, 2'd2}) begin
            $display("FAIL basic_grant: got grant=%b rdy=%b gv=%b idx=%0d want 0100/0/1/2",
                     a_grant, a_ready, a_gv, a_gidx);
            miscompares++;
        end
        a_rel = 4'b0100;
        tick();
        a_rel = 4'b0000;
        vectors++;
        if ({a_grant, a_ready, a_gv} !== {4'b0000, 1'b1, 1'b0}) begin
            $display("FAIL basic_release: got grant=%b rdy=%b gv=%b want 0000/1/0", a_grant, a_ready, a_gv);
            miscompares++;
        end
    endtask

    task automatic test_foreign_release();
        a_valid = 1'b1; a_idx = 2'd1;
        tick();
        a_valid = 1'b0;
        a_rel = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (a_grant !== 4'b0010) begin
                $display("FAIL foreign_release cyc%0d: got %b want 0010", i, a_grant);
                miscompares++;
            end
        end
        a_rel = 4'b0010;
        tick();
        a_rel = 4'b0000;
        vectors++;
        if ({a_grant, a_ready} !== {4'b0000, 1'b1}) begin
            $display("FAIL own_release: got grant=%b rdy=%b want 0000/1", a_grant, a_ready);
            miscompares++;
        end
    endtask

    task automatic test_timeout();
        t_valid = 1'b1; t_idx = 2'd3;
        tick();
        t_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({t_grant, t_to} !== {4'b1000, 1'b0}) begin
                $display("FAIL timeout_hold cyc%0d: got grant=%b to=%b want 1000/0", i + 1, t_grant, t_to);
                miscompares++;
            end
            tick();
        end
        vectors++;
        if ({t_grant, t_to} !== {4'b0000, 1'b1}) begin
            $display("FAIL timeout_expire: got grant=%b to=%b want 0000/1", t_grant, t_to);
            miscompares++;
        end
        tick();
        vectors++;
        if ({t_grant, t_to, t_ready} !== {4'b0000, 1'b0, 1'b1}) begin
            $display("FAIL timeout_pulse: got grant=%b to=%b rdy=%b want 0000/0/1", t_grant, t_to, t_ready);
            miscompares++;
        end
        // Matching release in the final hold cycle beats the timeout.
        t_valid = 1'b1; t_idx = 2'd3;
        tick();
        t_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        vectors++;
        if (t_grant !== 4'b1000) begin
            $display("FAIL timeout_8th_cycle: got %b want 1000", t_grant);
            miscompares++;
        end
        t_rel = 4'b1000;
        tick();
        t_rel = 4'b0000;
        vectors++;
        if ({t_grant, t_to} !== {4'b0000, 1'b0}) begin
            $display("FAIL release_beats_timeout: got grant=%b to=%b want 0000/0", t_grant, t_to);
            miscompares++;
        end
        tick();
        vectors++;
        if (t_to !== 1'b0) begin
            $display("FAIL release_beats_timeout_late: got to=%b want 0", t_to);
            miscompares++;
        end
    endtask

    task automatic test_out_of_range();
        f_valid = 1'b1; f_idx = 3'd6;
        tick();
        f_valid = 1'b0;
        vectors++;
        if ({f_err, f_grant, f_ready} !== {1'b1, 5'b00000, 1'b1}) begin
            $display("FAIL oor_err: got err=%b grant=%b rdy=%b want 1/00000/1", f_err, f_grant, f_ready);
            miscompares++;
        end
        tick();
        vectors++;
        if ({f_err, f_grant, f_ready} !== {1'b0, 5'b00000, 1'b1}) begin
            $display("FAIL oor_pulse: got err=%b grant=%b rdy=%b want 0/00000/1", f_err, f_grant, f_ready);
            miscompares++;
        end
        f_valid = 1'b1; f_idx = 3'd4;
        tick();
        f_valid = 1'b0;
        vectors++;
        if ({f_grant, f_err, f_gidx} !== {5'b10000, 1'b0, 3'd4}) begin
            $display("FAIL oor_then_idx4: got grant=%b err=%b idx=%0d want 10000/0/4", f_grant, f_err, f_gidx);
            miscompares++;
        end
        f_rel = 5'b10000;
        tick();
        f_rel = 5'b00000;
    endtask

    task automatic test_reset_mid_grant();
        a_valid = 1'b1; a_idx = 2'd0;
        tick();
        a_valid = 1'b0;
        vectors++;
        if (a_grant !== 4'b0001) begin
            $display("FAIL pre_reset_grant: got %b want 0001", a_grant);
            miscompares++;
        end
        #2 arst_n = 1'b0;
        #1;
        vectors++;
        if ({a_grant, a_ready} !== {4'b0000, 1'b1}) begin
            $display("FAIL async_reset: got grant=%b rdy=%b want 0000/1", a_grant, a_ready);
            miscompares++;
        end
        #3 arst_n = 1'b1;
        tick();
        vectors++;
        if ({a_grant, a_ready} !== {4'b0000, 1'b1}) begin
            $display("FAIL post_reset: got grant=%b rdy=%b want 0000/1", a_grant, a_ready);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0000;
        exp_seq[2] = 4'b0010;
        a_valid = 1'b1; a_idx = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            a_idx = 2'd1;
            a_rel = exp_seq[i];
            vectors++;
            if ((a_grant !== exp_seq[i]) || !$onehot0(a_grant)) begin
                $display("FAIL back_to_back step%0d: got %b want %b", i, a_grant, exp_seq[i]);
                miscompares++;
            end
        end
        a_valid = 1'b0;
        tick();
        a_rel = 4'b0000;
        vectors++;
        if ({a_grant, a_ready} !== {4'b0000, 1'b1}) begin
            $display("FAIL back_to_back_end: got grant=%b rdy=%b want 0000/1", a_grant, a_ready);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_foreign_release();
        test_timeout();
        test_out_of_range();
        test_reset_mid_grant();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arb_grant_decoder.md
# arb_grant_decoder

Registered decoder on the grant path of the bus arbiter: it accepts an encoded grant index from the arbiter's priority encoder through a valid/ready handshake and drives a one-hot grant to the selected requester. The grant is held until that requester releases it or an optional timeout expires. It sits between the arbiter core and the per-manager grant lines, and it is the only place where an encoded index turns back into a held one-hot grant.

## Interface
- WIDTH, 4: number of requesters; legal range is 2 or more.
- IDX_W, $clog2(WIDTH): index width; derived, do not override.
- TIMEOUT, 0: maximum grant hold in cycles; 0 disables the timeout.
- clk_i  input  1  clock, all state changes on the rising edge.
- arst_n_i  input  1  asynchronous active-low reset.
- enc_valid_i  input  1  encoded index valid.
- enc_idx_i  input  IDX_W  encoded requester index.
- enc_ready_o  output  1  decoder can accept an index.
- grant_o  output  WIDTH  one-hot grant, registered.
- grant_valid_o  output  1  a grant is currently held; equals |grant_o.
- grant_idx_o  output  IDX_W  registered index of the held grant.
- release_i  input  WIDTH  per-requester release, active high.
- timeout_o  output  1  one-cycle pulse when a grant is revoked by timeout.
- err_o  output  1  one-cycle pulse when an out-of-range index is accepted.

## Operation
- Two-state FSM with states IDLE and GRANT. Reset state is IDLE.
- enc_ready_o = (state == IDLE). It is combinational from the state register only, never from enc_valid_i.
- A transfer happens on a clock edge where enc_valid_i and enc_ready_o are both high.
- IDLE with a transfer and enc_idx_i < WIDTH:
  - grant_idx_o <= enc_idx_i.
  - grant_o <= 1 << enc_idx_i.
  - The timer clears.
  - Next state is GRANT.
- IDLE with a transfer and enc_idx_i >= WIDTH (possible only for non-power-of-two WIDTH):
  - The index is consumed.
  - err_o pulses high for one cycle.
  - grant_o stays 0 and the state stays IDLE.
- GRANT:
  - The timer increments every cycle.
  - If release_i[grant_idx_o] = 1: grant_o <= 0 and next state is IDLE.
  - release_i bits for any other index are ignored.
- Timeout applies only when TIMEOUT > 0:
  - When the timer reaches TIMEOUT-1 and there is no matching release in that cycle: grant_o <= 0, timeout_o pulses for one cycle, next state is IDLE.
  - If the matching release and the timeout occur in the same cycle, the release wins and timeout_o stays 0.
- The timer has width $clog2(TIMEOUT+1), minimum 1. It saturates and never wraps.
- enc_valid_i is ignored while in GRANT. The source must hold its index until enc_ready_o is high.

## Timing
- Reset values: grant_o=0, grant_valid_o=0, grant_idx_o=0, timeout_o=0, err_o=0, timer=0, state IDLE. Therefore enc_ready_o=1.
- Reset is asynchronous assert and synchronous-release safe. A reset asserted during GRANT drops grant_o immediately, without waiting for a clock edge.
- Accept to grant latency: 1 cycle. grant_o is high in the cycle after the transfer edge.
- Release to grant deassert latency: 1 cycle.
- Back-to-back grants have a minimum of one IDLE cycle between them, during which grant_o is 0.
- Grant hold with timeout: the grant is high for exactly TIMEOUT cycles. timeout_o is high in the first cycle that grant_o is low.
- err_o and timeout_o are registered pulses and are never high for two consecutive cycles.

## Structure
- No shared package is needed. IDX_W and the timer width are localparams.
- Natural sub-module: arb_grant_timer.
  - Contains the saturating counter with clear, enable and expire outputs.
  - Is instantiated only when TIMEOUT > 0, via a generate block.
  - When TIMEOUT = 0, expire is tied to 0.
- The decode is 1 << idx, inline; no separate module.

## Test plan
- Basic grant:
  - Stimulus: reset; WIDTH=4; present idx=2 with valid.
  - Required: grant_o=4'b0100 one cycle later and enc_ready_o=0.
  - Then assert release_i=4'b0100: grant_o=0 and enc_ready_o=1 the next cycle.
- Foreign release:
  - Stimulus: holding idx=1; release_i=4'b1101 for 5 cycles.
  - Required: grant_o stays 4'b0010. Then release_i=4'b0010 drops the grant in 1 cycle.
- Timeout:
  - Stimulus: TIMEOUT=8; grant idx=3; never release.
  - Required: grant_o=4'b1000 for exactly 8 cycles, then 0; timeout_o is a single 1-cycle pulse.
  - Also: matching release in the 8th cycle gives timeout_o=0.
- Out of range:
  - Stimulus: WIDTH=5; present idx=6.
  - Required: 1-cycle err_o pulse, grant_o=0, FSM stays in IDLE. A following idx=4 gives grant_o=5'b10000.
- Reset mid-grant:
  - Stimulus: assert arst_n_i=0 asynchronously while grant_o=4'b0001.
  - Required: grant_o=0 before the next clock edge. After release of reset, enc_ready_o=1.
- Back-to-back:
  - Stimulus: enc_valid_i held high with idx=0, then 1; each grant released immediately.
  - Required: grants 0001, 0000, 0010, with no overlapping one-hot bits in any cycle.
